// File: rtl/sync_filter_bank.sv
// Multi-channel level synchroniser with per-channel stability filter and
// registered rise/fall event pulses for bringing foreign-domain status lines into clk.
module sync_filter_bank #(
    parameter int               WIDTH      = 4,
    parameter int               STAGES     = 2,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    parameter int               FILTER_LEN = 4,
    localparam int              CNT_W      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    input  logic             flt_en,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_evt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

    logic [WIDTH-1:0] chain_q [STAGES];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             evt_q, evt_d;

    // Pure flop chain: any logic between stages would defeat metastability settling.
    // NOTE: every chain flop is reset to RST_VAL so the filter never sees a spurious edge at release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) chain_q[s] <= RST_VAL;
        end else begin
            chain_q[0] <= async_in;
            for (int s = 1; s < STAGES; s++) chain_q[s] <= chain_q[s-1];
        end
    end

    assign sync_out = chain_q[STAGES-1];

    // NOTE: all defaults are assigned first so no path through this block leaves a latch.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < WIDTH; i++) cnt_d[i] = '0;
        if (!flt_en) begin
            filt_d = sync_out;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_out[i] != filt_q[i]) begin
                    if (cnt_q[i] == CNT_MAX) filt_d[i] = sync_out[i];
                    else                     cnt_d[i]  = cnt_q[i] + 1'b1;
                end
            end
        end
        rise_d = filt_d & ~filt_q;
        fall_d = ~filt_d & filt_q;
        evt_d  = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            filt_q <= RST_VAL;
            rise_q <= '0;
            fall_q <= '0;
            evt_q  <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            filt_q <= filt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            evt_q  <= evt_d;
        end
    end

    assign filt_out = filt_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign any_evt  = evt_q;

endmodule

// File: tb/tb_sync_filter_bank.sv
// Directed bench for sync_filter_bank: reset, latency, glitch rejection, bypass,
// simultaneous channels and reset during a pending count.
module tb_sync_filter_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] async_in;
    logic       flt_en;
    logic [3:0] sync_out, filt_out, rise, fall;
    logic       any_evt;

    int n_checks = 0;
    int n_pass   = 0;

    sync_filter_bank #(
        .WIDTH(4), .STAGES(2), .RST_VAL(4'b0101), .FILTER_LEN(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .async_in(async_in), .flt_en(flt_en),
        .sync_out(sync_out), .filt_out(filt_out), .rise(rise), .fall(fall),
        .any_evt(any_evt)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        async_in = 4'b0101;
        flt_en   = 1'b1;
        settle(2);
        n_checks++;
        if ({sync_out, filt_out} !== {4'b0101, 4'b0101})
            $display("FAIL reset_vals: sync/filt=%b/%b expected 0101/0101", sync_out, filt_out);
        else n_pass++;
        n_checks++;
        if ({rise, fall, any_evt} !== 9'b0)
            $display("FAIL reset_pulses: rise/fall/any=%b/%b/%b expected 0", rise, fall, any_evt);
        else n_pass++;
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if ({rise, fall, any_evt, filt_out} !== {9'b0, 4'b0101})
                $display("FAIL release_c%0d: rise/fall/any/filt=%b/%b/%b/%b expected 0/0/0/0101",
                         k, rise, fall, any_evt, filt_out);
            else n_pass++;
        end
    endtask

    task automatic test_latency();
        async_in = 4'b0000;
        settle(10);
        async_in = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) begin
                n_checks++;
                if (sync_out[0] !== 1'b0) $display("FAIL lat_sync_e0: got %b expected 0", sync_out[0]);
                else n_pass++;
            end
            if (k == 2) begin
                n_checks++;
                if (sync_out[0] !== 1'b1) $display("FAIL lat_sync_e1: got %b expected 1", sync_out[0]);
                else n_pass++;
            end
            n_checks++;
            if ({filt_out[0], rise[0], any_evt} !== {k >= 6, k == 6, k == 6})
                $display("FAIL lat_c%0d: filt/rise/any=%b/%b/%b expected %b/%b/%b", k,
                         filt_out[0], rise[0], any_evt, k >= 6, k == 6, k == 6);
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        async_in[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_checks++;
            if ({filt_out[1], rise[1], fall[1]} !== 3'b000)
                $display("FAIL glitch3_c%0d: filt/rise/fall=%b/%b/%b expected 0/0/0",
                         k, filt_out[1], rise[1], fall[1]);
            else n_pass++;
            if (k == 3) async_in[1] = 1'b0;
        end
        async_in[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_checks++;
            if ({filt_out[1], rise[1], fall[1]} !== {k >= 6 && k <= 9, k == 6, k == 10})
                $display("FAIL pulse4_c%0d: filt/rise/fall=%b/%b/%b expected %b/%b/%b", k,
                         filt_out[1], rise[1], fall[1], k >= 6 && k <= 9, k == 6, k == 10);
            else n_pass++;
            if (k == 4) async_in[1] = 1'b0;
        end
    endtask

    task automatic test_bypass();
        logic [13:0] pat       = 14'h0333;
        logic [13:0] exp_filt  = 14'h0CCC;
        logic [13:0] exp_rise  = 14'h0444;
        logic [13:0] exp_fall  = 14'h1110;
        flt_en = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            async_in[2] = pat[k-1];
            tick();
            n_checks++;
            if ({filt_out[2], rise[2], fall[2], any_evt} !==
                {exp_filt[k-1], exp_rise[k-1], exp_fall[k-1], exp_rise[k-1] | exp_fall[k-1]})
                $display("FAIL bypass_c%0d: filt/rise/fall/any=%b/%b/%b/%b expected %b/%b/%b/%b", k,
                         filt_out[2], rise[2], fall[2], any_evt, exp_filt[k-1], exp_rise[k-1],
                         exp_fall[k-1], exp_rise[k-1] | exp_fall[k-1]);
            else n_pass++;
        end
        flt_en = 1'b1;
        settle(4);
        // Drop flt_en while channel 3 has counted to 2: value taken one edge early.
        async_in[3] = 1'b1;
        settle(4);
        n_checks++;
        if (filt_out[3] !== 1'b0) $display("FAIL midcnt_before: filt=%b expected 0", filt_out[3]);
        else n_pass++;
        flt_en = 1'b0;
        tick();
        n_checks++;
        if ({filt_out[3], rise[3]} !== 2'b11)
            $display("FAIL midcnt_take: filt/rise=%b/%b expected 1/1", filt_out[3], rise[3]);
        else n_pass++;
        flt_en = 1'b1;
        tick();
        n_checks++;
        if ({filt_out[3], rise[3]} !== 2'b10)
            $display("FAIL midcnt_after: filt/rise=%b/%b expected 1/0", filt_out[3], rise[3]);
        else n_pass++;
        settle(3);
        async_in[3] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_checks++;
            if ({filt_out[3], fall[3]} !== {k < 6, k == 6})
                $display("FAIL resume_c%0d: filt/fall=%b/%b expected %b/%b",
                         k, filt_out[3], fall[3], k < 6, k == 6);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        async_in = 4'b0000;
        settle(10);
        async_in = 4'b1111;
        settle(5);
        n_checks++;
        if ({filt_out, rise} !== 8'h00)
            $display("FAIL simul_pre: filt/rise=%b/%b expected 0000/0000", filt_out, rise);
        else n_pass++;
        tick();
        n_checks++;
        if ({filt_out, rise, fall, any_evt} !== {4'b1111, 4'b1111, 4'b0000, 1'b1})
            $display("FAIL simul_edge: filt/rise/fall/any=%b/%b/%b/%b expected 1111/1111/0000/1",
                     filt_out, rise, fall, any_evt);
        else n_pass++;
        tick();
        n_checks++;
        if ({rise, fall, any_evt} !== 9'b0)
            $display("FAIL simul_post: rise/fall/any=%b/%b/%b expected 0", rise, fall, any_evt);
        else n_pass++;
    endtask

    task automatic test_reset_midcount();
        async_in = 4'b0000;
        settle(10);
        async_in = 4'b1000;
        settle(4);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sync_out, filt_out, rise, fall, any_evt} !== {4'b0101, 4'b0101, 9'b0})
            $display("FAIL midrst_async: sync/filt/rise/fall/any=%b/%b/%b/%b/%b expected 0101/0101/0/0/0",
                     sync_out, filt_out, rise, fall, any_evt);
        else n_pass++;
        @(negedge clk);
        settle(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_checks++;
            if (k < 6 && {filt_out, rise, fall, any_evt} !== {4'b0101, 9'b0})
                $display("FAIL midrst_wait_c%0d: filt/rise/fall/any=%b/%b/%b/%b expected 0101/0/0/0",
                         k, filt_out, rise, fall, any_evt);
            else if (k == 6 && {filt_out, rise, fall, any_evt} !== {4'b1000, 4'b1000, 4'b0101, 1'b1})
                $display("FAIL midrst_edge: filt/rise/fall/any=%b/%b/%b/%b expected 1000/1000/0101/1",
                         filt_out, rise, fall, any_evt);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_bypass();
        test_back_to_back();
        test_reset_midcount();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
